// File: rtl/led_ctrl_pkg.sv
// Mode encoding shared between the LED pattern controller and the config-side logic.
// Codes 5-7 are reserved and fold to OFF through decode_mode().
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_PWM     = 3'd3,
    MODE_BREATHE = 3'd4
  } led_mode_e;

  localparam int MODE_W = 3;

  function automatic led_mode_e decode_mode(input logic [MODE_W-1:0] code);
    led_mode_e m;
    case (code)
      3'd1:    m = MODE_ON;
      3'd2:    m = MODE_BLINK;
      3'd3:    m = MODE_PWM;
      3'd4:    m = MODE_BREATHE;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: config registers, step divider, blink/breathe state and the mode mux.
// The raw output is combinational; the top registers it together with the enable gate.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int RATE_W = 4,
  parameter int PWM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              tick,
  input  logic [2:0]        cfg_mode,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic [PWM_W-1:0]  cfg_duty,
  input  logic [PWM_W-1:0]  pwm_cnt,
  output logic              raw
);

  localparam int SCW = (1 << RATE_W) - 1;
  localparam logic [SCW-1:0]   SC_ONE  = SCW'(1);
  localparam logic [SCW-1:0]   SC_ZERO = SCW'(0);
  localparam logic [PWM_W-1:0] LVL_MAX  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] LVL_ONE  = PWM_W'(1);
  localparam logic [PWM_W-1:0] LVL_ZERO = PWM_W'(0);

  led_mode_e         mode_q, mode_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic [SCW-1:0]    step_cnt_q, step_cnt_d;
  logic              blink_q, blink_d;
  logic [PWM_W-1:0]  level_q, level_d;
  logic              dir_dn_q, dir_dn_d;
  logic [SCW-1:0]    step_term;

  // Terminal count 2^rate-1; for the top rate the shift wraps to zero and the subtract gives all ones.
  assign step_term = (SC_ONE << rate_q) - SC_ONE;

  // Next-state: a write reloads the channel and suppresses any step from a coincident tick.
  always_comb begin
    mode_d     = mode_q;
    rate_d     = rate_q;
    duty_d     = duty_q;
    step_cnt_d = step_cnt_q;
    blink_d    = blink_q;
    level_d    = level_q;
    dir_dn_d   = dir_dn_q;
    if (we) begin
      mode_d     = decode_mode(cfg_mode);
      rate_d     = cfg_rate;
      duty_d     = cfg_duty;
      step_cnt_d = SC_ZERO;
      blink_d    = 1'b1;
      level_d    = LVL_ZERO;
      dir_dn_d   = 1'b0;
    end else if (tick) begin
      if (step_cnt_q == step_term) begin
        step_cnt_d = SC_ZERO;
        blink_d    = ~blink_q;
        if (!dir_dn_q && (level_q == LVL_MAX)) begin
          dir_dn_d = 1'b1;
          level_d  = LVL_MAX - LVL_ONE;
        end else if (dir_dn_q && (level_q == LVL_ZERO)) begin
          dir_dn_d = 1'b0;
          level_d  = LVL_ONE;
        end else if (dir_dn_q) begin
          level_d = level_q - LVL_ONE;
        end else begin
          level_d = level_q + LVL_ONE;
        end
      end else begin
        step_cnt_d = step_cnt_q + SC_ONE;
      end
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_OFF;
      rate_q     <= {RATE_W{1'b0}};
      duty_q     <= LVL_ZERO;
      step_cnt_q <= SC_ZERO;
      blink_q    <= 1'b0;
      level_q    <= LVL_ZERO;
      dir_dn_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      rate_q     <= rate_d;
      duty_q     <= duty_d;
      step_cnt_q <= step_cnt_d;
      blink_q    <= blink_d;
      level_q    <= level_d;
      dir_dn_q   <= dir_dn_d;
    end
  end

  // Mode mux.
  always_comb begin
    raw = 1'b0;
    case (mode_q)
      MODE_ON:      raw = 1'b1;
      MODE_BLINK:   raw = blink_q;
      MODE_PWM:     raw = (pwm_cnt < duty_q);
      MODE_BREATHE: raw = (pwm_cnt < level_q);
      default:      raw = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator: global tick prescaler, shared PWM counter,
// write decode to the per-channel engines, and the gated, registered LED outputs.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter int PRESCALE = 12000,
  parameter int RATE_W   = 4,
  parameter int PWM_W    = 8,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [2:0]          cfg_mode,
  input  logic [RATE_W-1:0]   cfg_rate,
  input  logic [PWM_W-1:0]    cfg_duty,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] led
);

  localparam int PSW = $clog2(PRESCALE);
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);
  localparam logic [PSW-1:0] PRESC_ZERO = PSW'(0);
  localparam logic [PSW-1:0] PRESC_ONE  = PSW'(1);

  logic [PSW-1:0]      presc_q, presc_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [CHANNELS-1:0] led_q, led_d;
  logic [CHANNELS-1:0] chan_we;
  logic [CHANNELS-1:0] raw;
  logic                tick;

  assign tick = (presc_q == PRESC_LAST);

  // Shared timebase and output gating.
  always_comb begin
    presc_d   = presc_q;
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    led_d     = enable & raw;
    if (tick) begin
      presc_d = PRESC_ZERO;
    end else begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // Out-of-range channel indices match no engine and are silently dropped.
  always_comb begin
    chan_we = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_we && (cfg_chan == CW'(i))) begin
        chan_we[i] = 1'b1;
      end else begin
        chan_we[i] = 1'b0;
      end
    end
  end

  // Timebase and LED output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= PRESC_ZERO;
      pwm_cnt_q <= PWM_W'(0);
      led_q     <= {CHANNELS{1'b0}};
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    led_channel #(
      .RATE_W(RATE_W),
      .PWM_W (PWM_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .we      (chan_we[i]),
      .tick    (tick),
      .cfg_mode(cfg_mode),
      .cfg_rate(cfg_rate),
      .cfg_duty(cfg_duty),
      .pwm_cnt (pwm_cnt_q),
      .raw     (raw[i])
    );
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl at PRESCALE=4, PWM_W=4, CHANNELS=5, RATE_W=4.
// Inputs change and outputs are sampled on the falling edge; cyc counts rising edges since reset release.
`timescale 1ns/1ps
module tb_led_pattern_ctrl;
  import led_ctrl_pkg::*;

  localparam int CH = 5;
  localparam int PS = 4;
  localparam int RW = 4;
  localparam int PW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_chan = 3'd0;
  logic [2:0]    cfg_mode = 3'd0;
  logic [RW-1:0] cfg_rate = 4'd0;
  logic [PW-1:0] cfg_duty = 4'd0;
  logic [CH-1:0] enable = 5'd0;
  logic [CH-1:0] led;

  int total = 0;
  int bad = 0;
  int cyc;
  int cnt;

  led_pattern_ctrl #(
    .CHANNELS(CH), .PRESCALE(PS), .RATE_W(RW), .PWM_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_mode(cfg_mode),
    .cfg_rate(cfg_rate), .cfg_duty(cfg_duty), .enable(enable), .led(led)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; the write is captured on the next rising edge.
  task automatic cfg_write(input int chan, input int mode, input int rate, input int duty);
    cfg_chan = CW'(chan);
    cfg_mode = 3'(mode);
    cfg_rate = RW'(rate);
    cfg_duty = PW'(duty);
    cfg_we   = 1'b1;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic count_bit(input int b, input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (led[b]) c++;
    end
  endtask

  task automatic align_to(input int ph);
    repeat (8) if (cyc % 4 != ph) @(negedge clk);
  endtask

  task automatic wait_led1(input logic lvl, output int at);
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin
      @(negedge clk);
      if (led[1] == lvl) at = cyc;
    end
  endtask

  // Blink on ch1 at rate 1 with the write captured on an edge where cyc%4 == ph.
  task automatic blink_run(input string tag, input int ph);
    int w, s1, t0, t1, t2;
    align_to((ph + 3) % 4);
    cfg_write(1, MODE_BLINK, 1, 0);
    w  = cyc;
    s1 = (w / 4 + 2) * 4;
    @(negedge clk);
    check_eq({tag, " start"}, int'(led[1]), 1);
    wait_led1(1'b0, t0);
    check_eq({tag, " first"}, t0, s1 + 1);
    wait_led1(1'b1, t1);
    check_eq({tag, " per1"}, t1 - t0, 8);
    wait_led1(1'b0, t2);
    check_eq({tag, " per2"}, t2 - t1, 8);
  endtask

  task automatic breathe_run();
    int w, n, s, m, lvl, act, exp;
    align_to(1);
    cfg_write(3, MODE_BREATHE, 0, 0);
    w = cyc;
    for (int j = 0; j < 9; j++) begin
      act = 0;
      exp = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        n   = cyc;
        s   = (n - 1) / 4 - w / 4;
        m   = s % 30;
        lvl = (m <= 15) ? m : 30 - m;
        if (((n - 1) % 16) < lvl) exp++;
        if (led[3]) act++;
      end
      check_eq($sformatf("breathe win%0d", j), act, exp);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    check_eq("reset led", int'(led), 0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    enable = 5'b11111;

    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (led != 5'd0) cnt++;
    end
    check_eq("idle off", cnt, 0);

    cfg_write(0, MODE_ON, 0, 0);
    check_eq("on edge t", int'(led[0]), 0);
    @(negedge clk);
    check_eq("on edge t+1", int'(led[0]), 1);
    enable[0] = 1'b0;
    @(negedge clk);
    check_eq("enable gate", int'(led[0]), 0);
    enable[0] = 1'b1;
    @(negedge clk);
    check_eq("enable back", int'(led[0]), 1);

    cfg_write(7, MODE_ON, 0, 15);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (led != 5'b00001) cnt++;
    end
    check_eq("bad chan", cnt, 0);

    cfg_write(4, MODE_ON, 0, 0);
    @(negedge clk);
    check_eq("ch4 on", int'(led[4]), 1);
    cfg_write(4, 6, 15, 15);
    @(negedge clk);
    count_bit(4, 32, cnt);
    check_eq("mode6 off", cnt, 0);

    cfg_write(2, MODE_PWM, 0, 4);
    @(negedge clk);
    count_bit(2, 16, cnt);
    check_eq("pwm duty4 a", cnt, 4);
    count_bit(2, 16, cnt);
    check_eq("pwm duty4 b", cnt, 4);
    cfg_write(2, MODE_PWM, 0, 0);
    @(negedge clk);
    count_bit(2, 32, cnt);
    check_eq("pwm duty0", cnt, 0);
    cfg_write(2, MODE_PWM, 0, 15);
    @(negedge clk);
    count_bit(2, 16, cnt);
    check_eq("pwm duty15", cnt, 15);

    blink_run("blink tick", 0);
    blink_run("blink mid", 2);

    breathe_run();

    @(negedge clk);
    check_eq("pre reset on", int'(led[0]), 1);
    #2 rst = 1'b1;
    #1 check_eq("async reset", int'(led), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (led != 5'd0) cnt++;
    end
    check_eq("post reset off", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
